bkram_sync: RTL

- Generalised backup-RAM ↔ SD-image sync engine for the console cores.
- Loads a mounted SAV image into cartridge NVRAM sector by sector.
- Tracks per-sector dirty bits from core NVRAM writes and writes back only dirty sectors, on manual request or by idle-timeout autosave.
- Sits between the core's nvram port and user_io's sd_* handshake; parametrised in NVRAM size and autosave delay.

---
 rtl/bkram_pkg.sv | 26 ++
 rtl/bkram_autosave_timer.sv | 43 ++++
 rtl/bkram_sync.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bkram_pkg.sv
// bkram_pkg: shared definitions for the backup-RAM sync engine.
//   - bk_state_t   : handshake/scan FSM states
//   - SECTOR_BYTES : bytes per SD sector / NVRAM sector
//   - SECTOR_LOG2  : log2(SECTOR_BYTES), byte-address bits inside a sector
//   - sector_count : ceil(bytes / SECTOR_BYTES), unsaturated
package bkram_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_LOG2  = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REQ,
    LOAD_ACK,
    DONE_LD,
    SCAN,
    SAVE_REQ,
    SAVE_ACK
  } bk_state_t;

  // 33-bit sum so a size near 4 GB cannot wrap before the shift.
  function automatic logic [23:0] sector_count(input logic [31:0] size);
    return 24'(({1'b0, size} + 33'(SECTOR_BYTES - 1)) >> SECTOR_LOG2);
  endfunction

endpackage

// File: rtl/bkram_autosave_timer.sv
// bkram_autosave_timer: idle-timeout counter for autosave.
//   clk_sys : system clock
//   rst_n   : asynchronous active-low reset
//   clear   : NVRAM write seen; restarts the idle count
//   enable  : count while something is dirty and autosave is allowed
//   fire    : one-cycle pulse once AUTOSAVE_DLY idle cycles have elapsed
module bkram_autosave_timer #(
  parameter int               DLY_W        = 24,
  parameter logic [DLY_W-1:0] AUTOSAVE_DLY = 24'd8_000_000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic fire
);

  localparam logic [DLY_W-1:0] FIRE_AT = AUTOSAVE_DLY - 1'b1;

  logic [DLY_W-1:0] count;

  // The step that would bring the count up to AUTOSAVE_DLY fires instead
  // and restarts from zero; the all-ones guard keeps the count saturated.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      fire  <= 1'b0;
    end else begin
      fire <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (enable) begin
        if (count == FIRE_AT) begin
          count <= '0;
          fire  <= 1'b1;
        end else if (count != '1) begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bkram_sync.sv
// bkram_sync: backup-RAM <-> SD image sync engine.
//   clk_sys, RESET_n        : clock, asynchronous active-low reset
//   img_mounted, img_size   : image mount level (rising edge = new image) and size
//   download                : ROM download level; rising edge invalidates backup
//   save_req, autosave_en   : manual save trigger, idle-timeout autosave enable
//   nvram_we, nvram_a       : core NVRAM write strobe and byte address
//   sd_lba, sd_rd, sd_wr    : sector request towards user_io
//   sd_ack                  : user_io transfer acknowledge
//   bk_ena                  : a valid backup image is mounted
//   bk_reset                : one-cycle pulse after a load completes
//   busy, dirty_any         : transfer in progress, any sector dirty
module bkram_sync
  import bkram_pkg::*;
#(
  parameter int               SECTOR_BITS  = 4,
  parameter int               DLY_W        = 24,
  parameter logic [DLY_W-1:0] AUTOSAVE_DLY = 24'd8_000_000
) (
  input  logic                      clk_sys,
  input  logic                      RESET_n,
  input  logic                      img_mounted,
  input  logic [31:0]               img_size,
  input  logic                      download,
  input  logic                      save_req,
  input  logic                      autosave_en,
  input  logic                      nvram_we,
  input  logic [SECTOR_BITS+8:0]    nvram_a,
  output logic [31:0]               sd_lba,
  output logic                      sd_rd,
  output logic                      sd_wr,
  input  logic                      sd_ack,
  output logic                      bk_ena,
  output logic                      bk_reset,
  output logic                      busy,
  output logic                      dirty_any
);

  localparam int IDX_W = (SECTOR_BITS > 0) ? SECTOR_BITS : 1;
  localparam int NS    = 1 << SECTOR_BITS;
  localparam logic [IDX_W:0] CUR_ONE = 1;

  bk_state_t state, state_next;

  logic mount_d, dl_d, save_d, ack_d;
  logic mount_edge, dl_edge, save_edge, ack_rise, ack_fall;

  logic             mount_pend, mount_zero, save_pend, abort;
  logic [IDX_W-1:0] mount_last, last_sect, n_last, we_idx, cur_idx;
  // One bit wider than a sector index so a scan can step past last_sect.
  logic [IDX_W:0]   cur;
  logic [23:0]      n_raw;
  logic [NS-1:0]    dirty, dirty_next;
  logic             abort_now, scan_end, auto_fire, unused_bits;

  assign mount_edge = img_mounted & ~mount_d;
  assign dl_edge    = download & ~dl_d;
  assign save_edge  = save_req & ~save_d;
  assign ack_rise   = sd_ack & ~ack_d;
  assign ack_fall   = ~sd_ack & ack_d;

  // A download edge in the current cycle aborts just like a latched one.
  assign abort_now = abort | dl_edge;
  assign cur_idx   = cur[IDX_W-1:0];
  assign scan_end  = cur > {1'b0, last_sect};
  assign busy      = (state != IDLE);
  assign dirty_any = |dirty;

  assign n_raw  = sector_count(img_size);
  assign n_last = (n_raw >= 24'(NS)) ? IDX_W'(NS - 1) : IDX_W'(n_raw - 24'd1);

  assign unused_bits = ^nvram_a[SECTOR_LOG2-1:0];

  generate
    if (SECTOR_BITS > 0) begin : g_we_idx
      assign we_idx = nvram_a[SECTOR_BITS+SECTOR_LOG2-1:SECTOR_LOG2];
    end else begin : g_we_idx0
      assign we_idx = 1'b0;
    end
  endgenerate

  bkram_autosave_timer #(
    .DLY_W        (DLY_W),
    .AUTOSAVE_DLY (AUTOSAVE_DLY)
  ) u_timer (
    .clk_sys (clk_sys),
    .rst_n   (RESET_n),
    .clear   (nvram_we),
    .enable  (dirty_any & autosave_en & bk_ena),
    .fire    (auto_fire)
  );

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!dl_edge) begin
          if (mount_pend) begin
            if (!mount_zero) state_next = LOAD_REQ;
          end else if (save_pend && bk_ena) begin
            state_next = SCAN;
          end
        end
      end
      LOAD_REQ: state_next = abort_now ? IDLE : LOAD_ACK;
      LOAD_ACK: begin
        if (ack_fall) begin
          if (abort_now)                   state_next = IDLE;
          else if (cur_idx == last_sect)   state_next = DONE_LD;
          else                             state_next = LOAD_REQ;
        end
      end
      DONE_LD:  state_next = IDLE;
      SCAN: begin
        if (abort_now || scan_end) state_next = IDLE;
        else if (dirty[cur_idx])   state_next = SAVE_REQ;
      end
      SAVE_REQ: state_next = abort_now ? IDLE : SAVE_ACK;
      SAVE_ACK: begin
        if (ack_fall) state_next = abort_now ? IDLE : SCAN;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Core writes are ORed in last so they win over any clear in the same cycle.
  always_comb begin
    dirty_next = dirty;
    if (dl_edge || state == DONE_LD) dirty_next = '0;
    else if (state == SAVE_ACK && ack_rise) dirty_next[cur_idx] = 1'b0;
    if (nvram_we) dirty_next[we_idx] = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) dirty <= '0;
    else          dirty <= dirty_next;
  end

  // Datapath and pending flags. New edges are latched after the per-state
  // updates so they are never lost, and a download edge overrides both.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      mount_d    <= 1'b0;
      dl_d       <= 1'b0;
      save_d     <= 1'b0;
      ack_d      <= 1'b0;
      mount_pend <= 1'b0;
      mount_zero <= 1'b0;
      mount_last <= '0;
      save_pend  <= 1'b0;
      abort      <= 1'b0;
      last_sect  <= '0;
      cur        <= '0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_ena     <= 1'b0;
      bk_reset   <= 1'b0;
    end else begin
      mount_d  <= img_mounted;
      dl_d     <= download;
      save_d   <= save_req;
      ack_d    <= sd_ack;
      bk_reset <= 1'b0;

      case (state)
        IDLE: begin
          abort <= 1'b0;
          if (!dl_edge) begin
            if (mount_pend) begin
              mount_pend <= 1'b0;
              if (mount_zero) begin
                bk_ena <= 1'b0;
              end else begin
                bk_ena    <= 1'b1;
                last_sect <= mount_last;
                cur       <= '0;
              end
            end else if (save_pend) begin
              if (bk_ena) cur <= '0;
              else        save_pend <= 1'b0;
            end
          end
        end
        LOAD_REQ: begin
          if (!abort_now) begin
            sd_lba <= 32'(cur_idx);
            sd_rd  <= 1'b1;
          end
        end
        LOAD_ACK: begin
          if (ack_rise) sd_rd <= 1'b0;
          if (ack_fall && cur_idx != last_sect) cur <= cur + CUR_ONE;
        end
        DONE_LD: bk_reset <= ~abort_now;
        SCAN: begin
          if (scan_end)            save_pend <= 1'b0;
          else if (!dirty[cur_idx]) cur <= cur + CUR_ONE;
        end
        SAVE_REQ: begin
          if (!abort_now) begin
            sd_lba <= 32'(cur_idx);
            sd_wr  <= 1'b1;
          end
        end
        SAVE_ACK: begin
          if (ack_rise) sd_wr <= 1'b0;
          if (ack_fall) cur <= cur + CUR_ONE;
        end
        default: ;
      endcase

      if (mount_edge) begin
        mount_pend <= 1'b1;
        mount_last <= n_last;
        mount_zero <= (img_size == 32'd0);
      end
      if (save_edge || auto_fire) save_pend <= 1'b1;

      if (dl_edge) begin
        bk_ena     <= 1'b0;
        save_pend  <= 1'b0;
        mount_pend <= 1'b0;
        abort      <= (state != IDLE);
      end
    end
  end

endmodule
